// File: rtl/rs232_rx.sv
// 8N1 asynchronous serial receiver with a valid/ack byte handshake.
// Flags framing errors (stop bit low) and overrun (byte lands while unread).
module rs232_rx #(
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter int unsigned SYNC_STAGES  = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       UART_RX,
    input  logic       ack,
    output logic [7:0] data,
    output logic       valid,
    output logic       receiving,
    output logic       frame_err,
    output logic       uart_ovf
);

    localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
    localparam int unsigned HALF  = CLKS_PER_BIT / 2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_BREAK
    } state_t;

    state_t                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [2:0]             bit_q, bit_d;
    logic [7:0]             shift_q, shift_d;
    logic                   load_q, load_d;
    logic [7:0]             data_q, data_d;
    logic                   valid_q, valid_d;
    logic                   frame_err_q, frame_err_d;
    logic                   uart_ovf_q, uart_ovf_d;
    logic                   rxs;
    logic                   bit_tick;

    assign rxs      = sync_q[SYNC_STAGES-1];
    assign bit_tick = (cnt_q == CNT_W'(CLKS_PER_BIT - 1));

    always_comb begin
        sync_d      = {sync_q[SYNC_STAGES-2:0], UART_RX};
        state_d     = state_q;
        cnt_d       = cnt_q;
        bit_d       = bit_q;
        shift_d     = shift_q;
        load_d      = 1'b0;
        data_d      = data_q;
        valid_d     = valid_q;
        frame_err_d = 1'b0;
        uart_ovf_d  = 1'b0;

        if (ack) begin
            valid_d = 1'b0;
        end
        // A byte load overrides a coincident ack; overrun only if nobody took the old byte.
        if (load_q) begin
            data_d     = shift_q;
            valid_d    = 1'b1;
            uart_ovf_d = valid_q && !ack;
        end

        case (state_q)
            S_IDLE: begin
                if (!rxs) begin
                    state_d = S_START;
                    cnt_d   = '0;
                end
            end
            S_START: begin
                if (cnt_q == CNT_W'(HALF - 1)) begin
                    cnt_d = '0;
                    if (rxs) begin
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_DATA;
                        bit_d   = 3'd0;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_DATA: begin
                if (bit_tick) begin
                    cnt_d   = '0;
                    shift_d = {rxs, shift_q[7:1]};
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
                        state_d = S_STOP;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_STOP: begin
                // Leave at mid-stop so the next start edge is seen without dead time.
                if (bit_tick) begin
                    cnt_d = '0;
                    if (rxs) begin
                        load_d  = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        frame_err_d = 1'b1;
                        state_d     = S_BREAK;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_BREAK: begin
                if (rxs) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            sync_q      <= '1;
            cnt_q       <= '0;
            bit_q       <= '0;
            shift_q     <= '0;
            load_q      <= 1'b0;
            data_q      <= '0;
            valid_q     <= 1'b0;
            frame_err_q <= 1'b0;
            uart_ovf_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            sync_q      <= sync_d;
            cnt_q       <= cnt_d;
            bit_q       <= bit_d;
            shift_q     <= shift_d;
            load_q      <= load_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
            frame_err_q <= frame_err_d;
            uart_ovf_q  <= uart_ovf_d;
        end
    end

    assign receiving = (state_q != S_IDLE);
    assign data      = data_q;
    assign valid     = valid_q;
    assign frame_err = frame_err_q;
    assign uart_ovf  = uart_ovf_q;

endmodule

// File: tb/tb_rs232_rx.sv
// Bench for rs232_rx: a frame table, randomized back-to-back traffic against a
// byte-queue model, and hand-written overrun / break / glitch / reset sequences.
module tb_rs232_rx;

    logic       clk = 1'b0;
    logic       rst;
    logic       UART_RX;
    logic       ack;
    logic [7:0] data;
    logic       valid;
    logic       receiving;
    logic       frame_err;
    logic       uart_ovf;

    always #5 clk = ~clk;

    rs232_rx #(.CLKS_PER_BIT(16), .SYNC_STAGES(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .UART_RX   (UART_RX),
        .ack       (ack),
        .data      (data),
        .valid     (valid),
        .receiving (receiving),
        .frame_err (frame_err),
        .uart_ovf  (uart_ovf)
    );

    int          n_checks = 0;
    int          n_fail   = 0;
    int unsigned cyc      = 0;
    int unsigned rise_cyc = 0;
    int unsigned fall_cyc = 0;
    int          ferr_cnt = 0;
    int          ovf_cnt  = 0;
    logic        valid_prev = 1'b0;
    logic [7:0]  load_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    // Observed byte deliveries: a valid rise or an overrun overwrite.
    always @(negedge clk) begin
        if (rst) begin
            valid_prev = 1'b0;
        end else begin
            if (valid && !valid_prev) begin
                rise_cyc = cyc;
                load_q.push_back(data);
            end
            if (uart_ovf) begin
                ovf_cnt++;
                load_q.push_back(data);
            end
            if (frame_err) ferr_cnt++;
            valid_prev = valid;
        end
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    // Line driver; p10 is the bit period in tenths of a clock so drift can be fractional.
    task automatic send_frame(input logic [7:0] b, input logic stop_v, input int p10);
        logic [9:0] bits;
        int total;
        bits  = {stop_v, b, 1'b0};
        total = (10 * p10 + 9) / 10;
        for (int c = 0; c < total; c++) begin
            @(negedge clk);
            if (c == 0) fall_cyc = cyc;
            UART_RX = bits[(c * 10) / p10];
        end
    endtask

    task automatic idle(input int cycles);
        repeat (cycles) begin
            @(negedge clk);
            UART_RX = 1'b1;
        end
    endtask

    task automatic clear_valid();
        @(negedge clk); ack = 1'b1;
        @(negedge clk); ack = 1'b0;
    endtask

    typedef struct {
        logic [7:0] b;
        logic       stop_v;
        int         p10;
        logic [7:0] exp_data;
        logic       exp_valid;
        int         exp_ferr;
    } vec_t;

    vec_t       vecs[8];
    logic [7:0] exp_q[$];
    logic [7:0] rb;
    int         f0, o0, base, lat, n_rand;
    bit         done;

    initial begin
        vecs[0] = '{8'hA5, 1'b1, 160, 8'hA5, 1'b1, 0};
        vecs[1] = '{8'h96, 1'b1, 170, 8'h96, 1'b1, 0};
        vecs[2] = '{8'h96, 1'b1, 153, 8'h96, 1'b1, 0};
        vecs[3] = '{8'h69, 1'b1, 167, 8'h69, 1'b1, 0};
        vecs[4] = '{8'h3C, 1'b0, 160, 8'h69, 1'b0, 1};
        vecs[5] = '{8'h81, 1'b1, 160, 8'h81, 1'b1, 0};
        vecs[6] = '{8'h00, 1'b1, 160, 8'h00, 1'b1, 0};
        vecs[7] = '{8'hFF, 1'b1, 160, 8'hFF, 1'b1, 0};

        rst = 1'b1; UART_RX = 1'b1; ack = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_data", 32'(data), 32'h00);
        check("reset_valid", 32'(valid), 32'd0);
        check("reset_receiving", 32'(receiving), 32'd0);
        check("reset_flags", 32'({frame_err, uart_ovf}), 32'd0);
        rst = 1'b0;
        idle(20);

        // Single frames, each followed by idle time; valid is cleared before each.
        for (int i = 0; i < 8; i++) begin
            if (valid) clear_valid();
            idle(4);
            f0 = ferr_cnt; o0 = ovf_cnt; base = load_q.size();
            send_frame(vecs[i].b, vecs[i].stop_v, vecs[i].p10);
            idle(48);
            check($sformatf("vec%0d_data", i), 32'(data), 32'(vecs[i].exp_data));
            check($sformatf("vec%0d_valid", i), 32'(valid), 32'(vecs[i].exp_valid));
            check($sformatf("vec%0d_ferr", i), 32'(ferr_cnt - f0), 32'(vecs[i].exp_ferr));
            check($sformatf("vec%0d_ovf", i), 32'(ovf_cnt - o0), 32'd0);
            check($sformatf("vec%0d_loads", i), 32'(load_q.size() - base), 32'(vecs[i].exp_valid));
            if (i == 0) begin
                lat = int'(rise_cyc) - int'(fall_cyc) - 1;
                check($sformatf("latency_%0d", lat), 32'(lat >= 154 && lat <= 156), 32'd1);
            end
        end

        // Back-to-back with ack one cycle after each valid rise, fixed then random bytes.
        for (int pass = 0; pass < 2; pass++) begin
            if (valid) clear_valid();
            idle(4);
            exp_q.delete();
            f0 = ferr_cnt; o0 = ovf_cnt; base = load_q.size();
            n_rand = (pass == 0) ? 3 : 8;
            done = 1'b0;
            fork
                begin
                    for (int k = 0; k < n_rand; k++) begin
                        if (pass == 0) begin
                            rb = (k == 0) ? 8'h00 : (k == 1) ? 8'hFF : 8'h55;
                            send_frame(rb, 1'b1, 160);
                        end else begin
                            rb = 8'($urandom_range(0, 255));
                            send_frame(rb, 1'b1, int'($urandom_range(154, 166)));
                            idle(int'($urandom_range(0, 20)));
                        end
                        exp_q.push_back(rb);
                    end
                    idle(48);
                    done = 1'b1;
                end
                begin
                    while (!done) begin
                        @(negedge clk);
                        if (ack) ack = 1'b0;
                        else if (valid) ack = 1'b1;
                    end
                end
            join
            ack = 1'b0;
            check($sformatf("b2b%0d_count", pass), 32'(load_q.size() - base), 32'(exp_q.size()));
            for (int k = 0; k < exp_q.size(); k++) begin
                if (base + k < load_q.size())
                    check($sformatf("b2b%0d_byte%0d", pass, k), 32'(load_q[base + k]), 32'(exp_q[k]));
            end
            check($sformatf("b2b%0d_ovf", pass), 32'(ovf_cnt - o0), 32'd0);
            check($sformatf("b2b%0d_ferr", pass), 32'(ferr_cnt - f0), 32'd0);
        end

        // Overrun: two bytes with nobody acking.
        if (valid) clear_valid();
        idle(4);
        o0 = ovf_cnt; base = load_q.size();
        send_frame(8'h12, 1'b1, 160);
        send_frame(8'h34, 1'b1, 160);
        idle(48);
        check("ovr_valid", 32'(valid), 32'd1);
        check("ovr_data", 32'(data), 32'h34);
        check("ovr_pulses", 32'(ovf_cnt - o0), 32'd1);
        check("ovr_loads", 32'(load_q.size() - base), 32'd2);
        if (load_q.size() >= base + 2) check("ovr_first", 32'(load_q[base]), 32'h12);

        // Framing error then recovery.
        clear_valid();
        f0 = ferr_cnt; base = load_q.size();
        send_frame(8'h3C, 1'b0, 160);
        idle(32);
        check("fe_valid_kept", 32'(valid), 32'd0);
        check("fe_data_kept", 32'(data), 32'h34);
        send_frame(8'h81, 1'b1, 160);
        idle(48);
        check("fe_pulses", 32'(ferr_cnt - f0), 32'd1);
        check("fe_recover_data", 32'(data), 32'h81);
        check("fe_recover_loads", 32'(load_q.size() - base), 32'd1);

        // 30-bit-time break.
        f0 = ferr_cnt; base = load_q.size();
        repeat (480) begin @(negedge clk); UART_RX = 1'b0; end
        check("brk_receiving", 32'(receiving), 32'd1);
        idle(48);
        check("brk_pulses", 32'(ferr_cnt - f0), 32'd1);
        check("brk_loads", 32'(load_q.size() - base), 32'd0);
        check("brk_idle", 32'(receiving), 32'd0);

        // Short glitch on the idle line.
        f0 = ferr_cnt; o0 = ovf_cnt; base = load_q.size();
        repeat (5) begin @(negedge clk); UART_RX = 1'b0; end
        check("glitch_start", 32'(receiving), 32'd1);
        idle(40);
        check("glitch_receiving", 32'(receiving), 32'd0);
        check("glitch_flags", 32'((ferr_cnt - f0) + (ovf_cnt - o0)), 32'd0);
        check("glitch_loads", 32'(load_q.size() - base), 32'd0);

        // Reset in the middle of bit 4, then a clean frame.
        begin
            logic [9:0] bits;
            bits = {1'b1, 8'hF0, 1'b0};
            for (int c = 0; c < 16 * 5 + 8; c++) begin
                @(negedge clk);
                UART_RX = bits[c / 16];
            end
        end
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("rst_mid_valid", 32'(valid), 32'd0);
        check("rst_mid_data", 32'(data), 32'h00);
        check("rst_mid_receiving", 32'(receiving), 32'd0);
        check("rst_mid_flags", 32'({frame_err, uart_ovf}), 32'd0);
        UART_RX = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        idle(32);
        f0 = ferr_cnt; base = load_q.size();
        send_frame(8'hC3, 1'b1, 160);
        idle(48);
        check("post_rst_data", 32'(data), 32'hC3);
        check("post_rst_valid", 32'(valid), 32'd1);
        check("post_rst_ferr", 32'(ferr_cnt - f0), 32'd0);
        check("post_rst_loads", 32'(load_q.size() - base), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
